// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one synchronous-read cell RAM between fixed-priority video
//            scanout and a valid/ready host port. Optional macro
//            VRAM_ARB_VBLANK_ONLY_EN restricts host access to vertical blanking.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [9:0]        i_HPos,
    input  logic [9:0]        i_VPos,
    input  logic              i_Visible,
    input  logic              i_HSync,
    input  logic              i_VSync,
    output logic              o_HSync,
    output logic              o_VSync,
    output logic [DATA_W-1:0] o_Color,
    input  logic              i_Host_Valid,
    input  logic              i_Host_Wr,
    input  logic [ADDR_W-1:0] i_Host_Addr,
    input  logic [DATA_W-1:0] i_Host_Wr_Data,
    output logic              o_Host_Ready,
    output logic              o_Host_Rd_Valid,
    output logic [DATA_W-1:0] o_Host_Rd_Data,
    output logic              o_Ram_En,
    output logic              o_Ram_We,
    output logic [ADDR_W-1:0] o_Ram_Addr,
    output logic [DATA_W-1:0] o_Ram_Wr_Data,
    input  logic [DATA_W-1:0] i_Ram_Rd_Data
);

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_VIDEO   = 2'd1,
        GNT_HOST_RD = 2'd2,
        GNT_HOST_WR = 2'd3
    } grant_t;

    localparam logic [ADDR_W-1:0] c_NUM_CELLS = ADDR_W'(COLS * ROWS);

    grant_t              grant_q, grant_d;
    logic                rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0]   cell_q, cell_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [1:0]          vis_q, vis_d;
    logic [1:0]          hs_q, hs_d;
    logic [1:0]          vs_q, vs_d;

    logic                w_video_slot;
    logic                w_vblank_ok;
    logic                w_host_ready;
    logic                w_host_fire;
    logic                w_host_in_range;
    logic [ADDR_W-1:0]   w_row;
    logic [ADDR_W-1:0]   w_col;
    logic [ADDR_W-1:0]   w_video_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_unused;

    assign w_unused = &{1'b0, i_VPos[9], i_VPos[2:0]};

    assign w_row        = ADDR_W'(i_VPos[8:3]);
    assign w_col        = ADDR_W'(i_HPos[9:3]);
    // Row stride of 80 cells built as 64 + 16 so no multiplier is needed.
    assign w_video_addr = (w_row << 6) + (w_row << 4) + w_col;

`ifdef VRAM_ARB_VBLANK_ONLY_EN
    assign w_vblank_ok = (i_VPos >= 10'd480);
`else
    assign w_vblank_ok = 1'b1;
`endif

    assign w_video_slot    = i_Visible && (i_HPos[2:0] == 3'd0);
    assign w_host_ready    = i_Rst_L && !w_video_slot && w_vblank_ok;
    assign w_host_fire     = i_Host_Valid && w_host_ready;
    assign w_host_in_range = (i_Host_Addr < c_NUM_CELLS);
    assign o_Host_Ready    = w_host_ready;

    always_comb begin : p_grant_next
        grant_d       = GNT_NONE;
        rd_oor_d      = rd_oor_q;
        o_Ram_En      = 1'b0;
        o_Ram_We      = 1'b0;
        o_Ram_Addr    = '0;
        o_Ram_Wr_Data = '0;
        if (i_Rst_L && w_video_slot) begin
            grant_d    = GNT_VIDEO;
            o_Ram_En   = 1'b1;
            o_Ram_Addr = w_video_addr;
        end else if (w_host_fire) begin
            o_Ram_Addr    = i_Host_Addr;
            o_Ram_Wr_Data = i_Host_Wr_Data;
            // Out-of-range accesses still take their grant cycle but never strobe the RAM.
            o_Ram_En      = w_host_in_range;
            if (i_Host_Wr) begin
                grant_d  = GNT_HOST_WR;
                o_Ram_We = w_host_in_range;
            end else begin
                grant_d  = GNT_HOST_RD;
                rd_oor_d = !w_host_in_range;
            end
        end
    end

    // Read data is forwarded in the completion cycle and captured to hold afterwards.
    assign o_Host_Rd_Valid = (grant_q == GNT_HOST_RD);
    assign w_rd_data       = o_Host_Rd_Valid ? (rd_oor_q ? '0 : i_Ram_Rd_Data) : rd_data_q;
    assign o_Host_Rd_Data  = w_rd_data;

    always_comb begin : p_pipe_next
        cell_d    = (grant_q == GNT_VIDEO) ? i_Ram_Rd_Data : cell_q;
        rd_data_d = w_rd_data;
        vis_d     = {vis_q[0], i_Visible};
        hs_d      = {hs_q[0], i_HSync};
        vs_d      = {vs_q[0], i_VSync};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin : p_regs
        if (!i_Rst_L) begin
            grant_q   <= GNT_NONE;
            rd_oor_q  <= 1'b0;
            cell_q    <= '0;
            rd_data_q <= '0;
            vis_q     <= '0;
            hs_q      <= '0;
            vs_q      <= '0;
        end else begin
            grant_q   <= grant_d;
            rd_oor_q  <= rd_oor_d;
            cell_q    <= cell_d;
            rd_data_q <= rd_data_d;
            vis_q     <= vis_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign o_Color = vis_q[1] ? cell_q : '0;
    assign o_HSync = hs_q[1];
    assign o_VSync = vs_q[1];

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, synchronous-read cell RAM between two requesters:
- **Video scanout:** fixed priority, fed by the sync generator's position outputs.
- **Host port:** valid/ready, driven by the UART command path.

The screen is 80x60 cells of 8x8 pixels, with one 9-bit RGB333 colour per cell. The block sits between the sync generator and the VGA pins. It delays sync and visible by the scanout pipeline depth so colour and sync leave aligned.

## Interface
Parameters:
- COLS, 80, cells per row
- ROWS, 60, cell rows
- ADDR_W, 13, RAM address width
- DATA_W, 9, cell colour width {R[2:0],G[2:0],B[2:0]}

Ports:
- i_Clk  in  1  pixel clock; all logic on rising edge
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_HPos  in  10  horizontal position from sync generator
- i_VPos  in  10  vertical position
- i_Visible  in  1  active-video flag
- i_HSync, i_VSync  in  1  active-high syncs from generator
- o_HSync, o_VSync  out  1  syncs delayed 2 cycles
- o_Color  out  DATA_W  pixel colour, 0 outside visible
- i_Host_Valid  in  1  host request present
- i_Host_Wr  in  1  1 = write, 0 = read
- i_Host_Addr  in  ADDR_W  cell address, row*COLS+col
- i_Host_Wr_Data  in  DATA_W  write data
- o_Host_Ready  out  1  request accepted this cycle when high with valid
- o_Host_Rd_Valid  out  1  one-cycle pulse, read data present
- o_Host_Rd_Data  out  DATA_W  read data
- o_Ram_En, o_Ram_We  out  1  RAM strobe / write enable
- o_Ram_Addr  out  ADDR_W  RAM address
- o_Ram_Wr_Data  out  DATA_W  RAM write data
- i_Ram_Rd_Data  in  DATA_W  RAM data, valid the cycle after the enabled read

## Operation
- **Video slot:**
  - Fires when i_Visible && i_HPos[2:0]==0.
  - The RAM is driven combinationally with address (i_VPos[8:3])*COLS + i_HPos[9:3], computed as shift-add (×64 + ×16).
  - The maximum address is 4799.
- **Host grant:**
  - o_Host_Ready = reset released && !video_slot. It is combinational.
  - A transfer occurs on a cycle where i_Host_Valid && o_Host_Ready.
  - Host signals are driven onto the RAM that same cycle.
- **Grant register:** a registered state records the previous cycle's owner as NONE, VIDEO, HOST_RD or HOST_WR.
  - VIDEO: i_Ram_Rd_Data loads the cell register.
  - HOST_RD: o_Host_Rd_Data <= i_Ram_Rd_Data and o_Host_Rd_Valid pulses.
- **Out-of-range host address (≥ COLS*ROWS):**
  - Write: dropped, o_Ram_En stays 0.
  - Read: completes with o_Host_Rd_Data = 0 and o_Host_Rd_Valid pulsing normally.
  - Either way it still consumes its ready cycle.
- **Collision:** video always wins. The host holds valid and stable until ready; the request must not be withdrawn.
- **Cell register:** holds its colour between video reads. o_Color = visible_d2 ? cell register : 0.

## Timing
- **Scanout latency:** 2 cycles.
  - Position presented at cycle N → its colour on o_Color at N+2.
  - o_HSync/o_VSync/visible are delayed identically.
- **Host read latency:** accept at N → o_Host_Rd_Valid/o_Host_Rd_Data at N+1. Rd_Data holds until the next read completes.
- **Host throughput:** 7 of 8 cycles while visible; every cycle in blanking.
- **Write-then-read** of the same address on consecutive cycles returns the new data.
- **Reset values (asynchronous):**
  - o_Color, o_HSync, o_VSync, o_Host_Rd_Valid, o_Host_Rd_Data all 0.
  - Grant state = NONE; cell register = 0.
- **While i_Rst_L low:** o_Ram_En, o_Ram_We and o_Host_Ready are forced 0.
- **Reset mid-read:** a read accepted on the cycle reset asserts produces no Rd_Valid pulse.

## Configuration
- **VRAM_ARB_VBLANK_ONLY_EN defined:** o_Host_Ready is additionally gated by i_VPos ≥ 480, so the host accesses RAM only in vertical blanking (tear-free). Requests during active lines stall until line 480.
- **Not defined:** host is granted in any non-video cycle, as above.

## Test plan
- **Reset:** hold i_Rst_L=0 with i_Host_Valid=1 → every output 0, o_Ram_En=0, o_Host_Ready=0.
- **Write then scanout:** during vblank write 0x1C0 to addr 0 → next frame o_Color=0x1C0 for 8 cycles starting 2 cycles after (hpos=0, vpos=0). Address 1, never written, returns 0.
- **Collision:** valid write asserted at hpos=8, visible → ready=0 that cycle. Accepted at hpos=9. The video read at hpos=8 returns its cell unaffected.
- **Read at edge:** write 0x0A5 to addr 4799, then read it → o_Host_Rd_Valid pulse one cycle after accept with data 0x0A5. Pixel (639,479) shows 0x0A5.
- **Out of range:** write 0x1FF to addr 4800 → o_Ram_En=0. Read 4800 → Rd_Valid with data 0.
- **With VRAM_ARB_VBLANK_ONLY_EN:** request at vpos=100 stalls (ready=0) until vpos=480 line start, then completes. Without the macro it completes within 1 cycle.
